// File: rtl/regfile_pkg.sv
// Shared constants for the multi-context register file: FSM encodings, CtxOp codes, defaults.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned NUM_REGS_DEF = 32;
  localparam int unsigned NUM_CTX_DEF  = 4;

  typedef logic [1:0] fsm_state_t;

  localparam fsm_state_t ST_IDLE    = 2'd0;
  localparam fsm_state_t ST_SAVE    = 2'd1;
  localparam fsm_state_t ST_RESTORE = 2'd2;

  localparam logic CTX_SAVE    = 1'b0;
  localparam logic CTX_RESTORE = 1'b1;

  // Index width for an array of n entries, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_ctx_fsm.sv
// Save/restore sequencer: command handshake, copy pointer and status pulses.
module regfile_ctx_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned NUM_CTX  = NUM_CTX_DEF,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
  parameter int unsigned CTX_W    = clog2_min1(NUM_CTX),
  parameter int unsigned CI_W     = clog2_min1(NUM_CTX)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ctx_valid,
  input  logic              ctx_op,
  input  logic [CTX_W-1:0]  ctx_id,
  input  logic              reg_write,
  output logic              ctx_ready,
  output logic              ctx_busy,
  output logic              ctx_done,
  output logic              ctx_err,
  output logic              wr_drop,
  output logic              copy_en,
  output logic              copy_dir,
  output logic [ADDR_W-1:0] copy_idx,
  output logic [CI_W-1:0]   copy_ctx
);

  localparam logic [ADDR_W-1:0] PtrOne = {{(ADDR_W-1){1'b0}}, 1'b1};

  fsm_state_t        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CI_W-1:0]   ctx_q, ctx_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              drop_q, drop_d;
  logic              id_ok;

  assign id_ok = 32'(ctx_id) < NUM_CTX;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ctx_d   = ctx_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    drop_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ctx_valid) begin
          if (id_ok) begin
            ctx_d   = ctx_id[CI_W-1:0];
            ptr_d   = PtrOne;
            state_d = (ctx_op == CTX_RESTORE) ? ST_RESTORE : ST_SAVE;
          end else begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end
        end
      end
      ST_SAVE, ST_RESTORE: begin
        drop_d = reg_write;
        // Last register copied this edge; the pointer never wraps to r0.
        if (&ptr_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          ptr_d = ptr_q + PtrOne;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      ctx_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ctx_q   <= ctx_d;
      done_q  <= done_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
    end
  end

  assign ctx_ready = (state_q == ST_IDLE);
  assign ctx_busy  = (state_q != ST_IDLE);
  assign ctx_done  = done_q;
  assign ctx_err   = err_q;
  assign wr_drop   = drop_q;
  assign copy_en   = (state_q != ST_IDLE);
  assign copy_dir  = (state_q == ST_RESTORE);
  assign copy_idx  = ptr_q;
  assign copy_ctx  = ctx_q;

endmodule

// File: rtl/regfile_ctx.sv
// Multi-context MIPS register file: active bank, NUM_CTX shadow banks, save/restore engine.
// Optional write-through read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_ctx
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
  parameter int unsigned NUM_CTX  = NUM_CTX_DEF,
  parameter int unsigned CTX_W    = clog2_min1(NUM_CTX)
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              CtxValid,
  input  logic              CtxOp,
  input  logic [CTX_W-1:0]  CtxId,
  output logic              CtxReady,
  output logic              CtxBusy,
  output logic              CtxDone,
  output logic              CtxErr,
  output logic              WrDrop
);

  localparam int unsigned CI_W = clog2_min1(NUM_CTX);

  logic [DATA_W-1:0] active_q [NUM_REGS];
  logic [DATA_W-1:0] shadow_q [NUM_CTX][NUM_REGS];

  logic              copy_en;
  logic              copy_dir;
  logic [ADDR_W-1:0] copy_idx;
  logic [CI_W-1:0]   copy_ctx;
  logic              wr_en;

  regfile_ctx_fsm #(
    .NUM_REGS (NUM_REGS),
    .NUM_CTX  (NUM_CTX),
    .ADDR_W   (ADDR_W),
    .CTX_W    (CTX_W),
    .CI_W     (CI_W)
  ) u_fsm (
    .clk       (CLK),
    .rst_n     (RSTn),
    .ctx_valid (CtxValid),
    .ctx_op    (CtxOp),
    .ctx_id    (CtxId),
    .reg_write (RegWrite),
    .ctx_ready (CtxReady),
    .ctx_busy  (CtxBusy),
    .ctx_done  (CtxDone),
    .ctx_err   (CtxErr),
    .wr_drop   (WrDrop),
    .copy_en   (copy_en),
    .copy_dir  (copy_dir),
    .copy_idx  (copy_idx),
    .copy_ctx  (copy_ctx)
  );

  assign wr_en = RegWrite && CtxReady && (WriteReg != '0);

  // Copies only run while not IDLE and writes only while IDLE, so they never collide.
  always_ff @(negedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int r = 0; r < int'(NUM_REGS); r++) begin
        active_q[r] <= '0;
      end
      for (int c = 0; c < int'(NUM_CTX); c++) begin
        for (int r = 0; r < int'(NUM_REGS); r++) begin
          shadow_q[c][r] <= '0;
        end
      end
    end else if (copy_en) begin
      if (copy_dir == CTX_RESTORE) begin
        active_q[copy_idx] <= shadow_q[copy_ctx][copy_idx];
      end else begin
        shadow_q[copy_ctx][copy_idx] <= active_q[copy_idx];
      end
    end else if (wr_en) begin
      active_q[WriteReg] <= WriteData;
    end
  end

  always_comb begin
    ReadData1 = (ReadReg1 == '0) ? '0 : active_q[ReadReg1];
    ReadData2 = (ReadReg2 == '0) ? '0 : active_q[ReadReg2];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (WriteReg == ReadReg1)) ReadData1 = WriteData;
    if (wr_en && (WriteReg == ReadReg2)) ReadData2 = WriteData;
`endif
  end

endmodule

// File: tb/tb_regfile_ctx.sv
// Directed bench for regfile_ctx: vector table for basic writes/reads, sequences for context ops.
module tb_regfile_ctx;

  logic        CLK = 1'b1;
  logic        RSTn;
  logic [4:0]  ReadReg1, ReadReg2, WriteReg;
  logic [31:0] ReadData1, ReadData2, WriteData;
  logic        RegWrite, CtxValid, CtxOp;
  logic [2:0]  CtxId;
  logic        CtxReady, CtxBusy, CtxDone, CtxErr, WrDrop;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  regfile_ctx #(
    .DATA_W   (32),
    .NUM_REGS (32),
    .NUM_CTX  (4),
    .CTX_W    (3)
  ) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .ReadReg1  (ReadReg1),
    .ReadReg2  (ReadReg2),
    .ReadData1 (ReadData1),
    .ReadData2 (ReadData2),
    .RegWrite  (RegWrite),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .CtxValid  (CtxValid),
    .CtxOp     (CtxOp),
    .CtxId     (CtxId),
    .CtxReady  (CtxReady),
    .CtxBusy   (CtxBusy),
    .CtxDone   (CtxDone),
    .CtxErr    (CtxErr),
    .WrDrop    (WrDrop)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    RegWrite = 1'b1; WriteReg = a; WriteData = d;
    tick();
    RegWrite = 1'b0;
  endtask

  task automatic rd1(input logic [4:0] a, output logic [31:0] d);
    ReadReg1 = a;
    #1 d = ReadData1;
  endtask

  // Issue one command, then observe a fixed 40-cycle window counting status pulses.
  task automatic run_cmd(input logic op, input logic [2:0] id,
                         output int busy_n, output int done_n, output int err_n);
    busy_n = 0; done_n = 0; err_n = 0;
    CtxValid = 1'b1; CtxOp = op; CtxId = id;
    tick();
    CtxValid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (CtxBusy) busy_n++;
      if (CtxDone) done_n++;
      if (CtxErr) err_n++;
      if (k < 39) tick();
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!CtxReady && k < 100) begin
      tick();
      k++;
    end
    check("idle_timeout", {31'd0, CtxReady}, 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    int bn, dn, en, seen;

    RSTn = 1'b0; RegWrite = 1'b0; WriteReg = '0; WriteData = '0;
    ReadReg1 = 5'd5; ReadReg2 = 5'd31; CtxValid = 1'b0; CtxOp = 1'b0; CtxId = '0;
    #3;
    check("rst_ready", {31'd0, CtxReady}, 32'd1);
    check("rst_flags", {27'd0, CtxBusy, CtxDone, CtxErr, WrDrop, 1'b0}, 32'd0);
    check("rst_rd1", ReadData1, 32'd0);
    check("rst_rd2", ReadData2, 32'd0);
    #9 RSTn = 1'b1;

    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd5,  32'hCAFEF00D, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 5'd5,  32'h00000001, 5'd5,  5'd31, 32'h00000001, 32'hCAFEF00D};
    vecs[4] = '{1'b0, 5'd5,  32'hFFFFFFFF, 5'd5,  5'd1,  32'h00000001, 32'h0};
    vecs[5] = '{1'b1, 5'd1,  32'h80000000, 5'd1,  5'd5,  32'h80000000, 32'h00000001};

    for (int i = 0; i < 6; i++) begin
      RegWrite = vecs[i].we; WriteReg = vecs[i].wreg; WriteData = vecs[i].wdata;
      tick();
      RegWrite = 1'b0;
      ReadReg1 = vecs[i].rr1; ReadReg2 = vecs[i].rr2;
      #1;
      check($sformatf("vec%0d_rd1", i), ReadData1, vecs[i].exp1);
      check($sformatf("vec%0d_rd2", i), ReadData2, vecs[i].exp2);
    end

    // Save/clear/restore round trip through context 2.
    for (int r = 1; r < 32; r++) wr(5'(r), 32'(r));
    run_cmd(1'b0, 3'd2, bn, dn, en);
    check("save_busy", 32'(bn), 32'd31);
    check("save_done", 32'(dn), 32'd1);
    check("save_err", 32'(en), 32'd0);
    for (int r = 1; r < 32; r++) wr(5'(r), 32'd0);
    rd1(5'd10, d);
    check("cleared_r10", d, 32'd0);
    run_cmd(1'b1, 3'd2, bn, dn, en);
    check("restore_busy", 32'(bn), 32'd31);
    check("restore_done", 32'(dn), 32'd1);
    for (int r = 0; r < 32; r++) begin
      rd1(5'(r), d);
      check($sformatf("restored_r%0d", r), d, 32'(r));
    end

    // Out-of-range context id.
    run_cmd(1'b0, 3'd5, bn, dn, en);
    check("badid_busy", 32'(bn), 32'd0);
    check("badid_done", 32'(dn), 32'd1);
    check("badid_err", 32'(en), 32'd1);
    rd1(5'd9, d);
    check("badid_r9", d, 32'd9);

    // Write during SAVE is dropped.
    CtxValid = 1'b1; CtxOp = 1'b0; CtxId = 3'd1;
    tick();
    CtxValid = 1'b0;
    tick();
    RegWrite = 1'b1; WriteReg = 5'd7; WriteData = 32'h1234;
    tick();
    RegWrite = 1'b0;
    check("wrdrop_pulse", {31'd0, WrDrop}, 32'd1);
    tick();
    check("wrdrop_clear", {31'd0, WrDrop}, 32'd0);
    wait_idle();
    rd1(5'd7, d);
    check("wrdrop_r7", d, 32'd7);

    // Same-edge write and save accept: shadow captures the new value.
    RegWrite = 1'b1; WriteReg = 5'd7; WriteData = 32'h55;
    CtxValid = 1'b1; CtxOp = 1'b0; CtxId = 3'd3;
    tick();
    RegWrite = 1'b0; CtxValid = 1'b0;
    check("same_edge_busy", {31'd0, CtxBusy}, 32'd1);
    check("same_edge_nodrop", {31'd0, WrDrop}, 32'd0);
    wait_idle();
    wr(5'd7, 32'd0);
    run_cmd(1'b1, 3'd3, bn, dn, en);
    rd1(5'd7, d);
    check("shadow3_r7", d, 32'h55);
    rd1(5'd8, d);
    check("shadow3_r8", d, 32'd8);

    // Reset in the middle of a restore.
    CtxValid = 1'b1; CtxOp = 1'b1; CtxId = 3'd2;
    tick();
    CtxValid = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    #2 RSTn = 1'b0;
    #1;
    rd1(5'd5, d);
    check("midrst_r5", d, 32'd0);
    check("midrst_ready", {31'd0, CtxReady}, 32'd1);
    check("midrst_busy", {31'd0, CtxBusy}, 32'd0);
    @(posedge CLK);
    RSTn = 1'b1;
    seen = 0;
    for (int k = 0; k < 35; k++) begin
      tick();
      if (CtxDone) seen++;
    end
    check("midrst_nodone", 32'(seen), 32'd0);
    wr(5'd5, 32'd1);
    run_cmd(1'b1, 3'd2, bn, dn, en);
    rd1(5'd5, d);
    check("midrst_shadow_cleared", d, 32'd0);

    // Same-cycle read of a register being written.
    wr(5'd3, 32'h33);
    RegWrite = 1'b1; WriteReg = 5'd3; WriteData = 32'hA5A5A5A5; ReadReg2 = 5'd3;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass_rd2", ReadData2, 32'hA5A5A5A5);
`else
    check("bypass_rd2", ReadData2, 32'h33);
`endif
    tick();
    RegWrite = 1'b0;
    #1;
    check("after_edge_rd2", ReadData2, 32'hA5A5A5A5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_ctx.md
Name: regfile_ctx

Overview:
- Parametrised multi-context general-purpose register file for the MIPS datapath; successor to the single-bank register file with one-shot dump/load.
- Holds one active bank plus NUM_CTX shadow banks.
- A sequential save/restore engine copies the active bank to or from a selected shadow bank, one register per cycle, under a valid/ready command handshake.
- Register 0 reads as zero in every bank; two combinational read ports, one write port.

Parameters:
- DATA_W, 32, register width in bits
- NUM_REGS, 32, registers per bank, power of two, >=4
- ADDR_W, $clog2(NUM_REGS), register address width
- NUM_CTX, 4, number of shadow banks, >=1
- CTX_W, $clog2(NUM_CTX) (minimum 1), context id width

Ports:
- CLK  in  1  clock; all state updates on falling edge
- RSTn  in  1  asynchronous active-low reset
- ReadReg1  in  ADDR_W  read port 1 address
- ReadReg2  in  ADDR_W  read port 2 address
- ReadData1  out  DATA_W  read port 1 data
- ReadData2  out  DATA_W  read port 2 data
- RegWrite  in  1  write enable
- WriteReg  in  ADDR_W  write address
- WriteData  in  DATA_W  write data
- CtxValid  in  1  context command valid
- CtxOp  in  1  0 = save (active to shadow), 1 = restore (shadow to active)
- CtxId  in  CTX_W  target shadow bank
- CtxReady  out  1  engine idle, command can be accepted
- CtxBusy  out  1  copy in progress
- CtxDone  out  1  one-cycle pulse when a command completes
- CtxErr  out  1  one-cycle pulse with CtxDone on an invalid CtxId
- WrDrop  out  1  one-cycle pulse when a write is discarded while busy

Behaviour:
- Reset (RSTn low, asynchronous):
  - all active and shadow registers = 0; FSM = IDLE.
  - CtxReady = 1; CtxBusy, CtxDone, CtxErr, WrDrop = 0.
  - A reset asserted mid-copy aborts the copy; the partial copy is discarded because all banks are cleared.
- Reads:
  - Combinational: ReadDataN = active[ReadRegN]; address 0 returns 0.
- Writes:
  - Applied on the falling edge when RegWrite=1, WriteReg!=0 and the FSM is IDLE.
  - Writes to register 0 are ignored silently.
  - RegWrite=1 while CtxBusy: write discarded, WrDrop pulses next edge. The core is responsible for stalling.
- Handshake:
  - A command is accepted on a falling edge with CtxValid=1 and CtxReady=1.
  - CtxReady = (state==IDLE).
- FSM states: IDLE, SAVE, RESTORE.
  - IDLE, command accepted, CtxId<NUM_CTX: latch CtxId; pointer = 1; go to SAVE (CtxOp=0) or RESTORE (CtxOp=1).
  - IDLE, command accepted, CtxId>=NUM_CTX: stay IDLE; CtxDone and CtxErr pulse on the next edge; no data moves.
  - SAVE: each edge shadow[id][ptr] <= active[ptr]; ptr++.
  - RESTORE: each edge active[ptr] <= shadow[id][ptr]; ptr++.
  - When ptr==NUM_REGS-1, that copy completes, the FSM returns to IDLE and CtxDone pulses for that same cycle.
- Latency and busy:
  - Exactly NUM_REGS-1 busy cycles per valid command (31 by default).
  - CtxBusy = state!=IDLE.
  - A new command can be accepted on the first edge back in IDLE.
- Simultaneous write and command accept (both in IDLE): the write commits on that edge; the copy starts on the next edge and sees the written value.
- Reads during RESTORE return a mix of old and restored values and are not guaranteed.
- Pointer arithmetic is ADDR_W bits wide; the FSM exits before wrap-around. Register 0 is never copied.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: when RegWrite=1, FSM IDLE, WriteReg!=0 and WriteReg==ReadRegN, ReadDataN returns WriteData combinationally (write-through forwarding).
- Undefined: ReadDataN returns the stored value only; the new value is visible after the falling edge.

Decomposition:
- Shared package regfile_pkg holds:
  - the FSM state enum (IDLE, SAVE, RESTORE);
  - the CtxOp encodings CTX_SAVE=0, CTX_RESTORE=1;
  - default DATA_W/NUM_REGS constants.
- One sub-module, regfile_ctx_fsm, holds the handshake, state, pointer and pulse outputs. It drives copy enable, direction and index to the storage in regfile_ctx.

Test Plan:
- Reset, then write 0xDEADBEEF to r5 -> ReadReg1=5 returns 0xDEADBEEF after the falling edge; write to r0 -> r0 still reads 0.
- Fill r1..r31 with value=index, save to ctx 2, overwrite all with 0, restore ctx 2 -> each rN reads N. CtxBusy high exactly 31 cycles per command; CtxDone a single pulse each.
- Command with CtxId=5 when NUM_CTX=4 (CTX_W=3) -> no busy cycles, CtxDone and CtxErr pulse together, registers unchanged.
- RegWrite r7=0x1234 during SAVE -> WrDrop pulses, r7 retains its old value. Same-edge write r7=0x55 plus save accept -> shadow r7 = 0x55.
- RSTn low at copy cycle 10 of a restore -> all reads 0, CtxReady=1 immediately, no CtxDone pulse.
- With REGFILE_BYPASS_EN: RegWrite r3=0xA5A5A5A5, ReadReg2=3 in the same cycle -> ReadData2=0xA5A5A5A5 before the edge. Without the macro -> old r3 value.
